// File: rtl/ctr_pkg.sv
// Shared definitions for the cascaded counter: slice width, wrap-counter
// width default and the 4-bit slice next-state/carry function.
package ctr_pkg;

  localparam int SLICE_W        = 4;
  localparam int WRAP_CNT_W_DEF = 8;

  // Returns {next_value, carry_out} for one 4-bit slice.
  function automatic logic [SLICE_W:0] slice_next(
    input logic [SLICE_W-1:0] cur,
    input logic               en_p,
    input logic               en_t,
    input logic               cin
  );
    logic [SLICE_W-1:0] nxt;
    logic               cout;
    nxt  = (en_p & en_t & cin) ? cur + 4'd1 : cur;
    cout = en_t & cin & (cur == 4'hF);
    return {nxt, cout};
  endfunction

endpackage

// File: rtl/ctr_slice4.sv
// Combinational 4-bit counter slice: next value and ripple carry out.
module ctr_slice4
  import ctr_pkg::*;
(
  input  logic [SLICE_W-1:0] cur,
  input  logic               en_p,
  input  logic               en_t,
  input  logic               cin,
  output logic [SLICE_W-1:0] nxt,
  output logic               cout
);

  assign {nxt, cout} = slice_next(cur, en_p, en_t, cin);

endmodule

// File: rtl/cascade_counter_reg.sv
// Registered cascade of 4-bit counter slices with parallel-load handshake,
// synchronous clear, terminal-count and saturating wrap tracking.
module cascade_counter_reg
  import ctr_pkg::*;
#(
  parameter int SLICES     = 4,
  parameter int WRAP_CNT_W = WRAP_CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      en_p,
  input  logic                      en_t,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [SLICE_W*SLICES-1:0] load_data,
  output logic [SLICE_W*SLICES-1:0] count,
  output logic                      rco,
  output logic                      tc_q,
  output logic                      wrap_pulse,
  output logic [WRAP_CNT_W-1:0]     wrap_cnt
);

  localparam int WIDTH = SLICE_W * SLICES;

  logic [SLICES:0]  carry;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_nxt;
  logic             ready_q;
  logic             load_acc;
  logic             wrap_evt;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    ctr_slice4 u_slice (
      .cur  (count[i*SLICE_W +: SLICE_W]),
      .en_p (en_p),
      .en_t (en_t),
      .cin  (carry[i]),
      .nxt  (count_inc[i*SLICE_W +: SLICE_W]),
      .cout (carry[i+1])
    );
  end

  // The last carry already folds in en_t and the all-ones test.
  assign rco        = carry[SLICES];
  assign load_ready = ready_q & ~clear;
  assign load_acc   = load_valid & load_ready;
  assign wrap_evt   = ~clear & ~load_acc & en_p & carry[SLICES];

  always_comb begin
    count_nxt = count_inc;
    if (clear) begin
      count_nxt = '0;
    end else if (load_acc) begin
      count_nxt = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      ready_q    <= 1'b0;
      tc_q       <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      count      <= count_nxt;
      ready_q    <= ~load_acc;
      tc_q       <= (count_nxt == {WIDTH{1'b1}});
      wrap_pulse <= wrap_evt;
      if (clear) begin
        wrap_cnt <= '0;
      end else if (wrap_evt && (wrap_cnt != {WRAP_CNT_W{1'b1}})) begin
        wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cascade_counter_reg.sv
// Directed bench: a 1-slice instance with a 2-bit wrap counter and a
// 4-slice instance with the default wrap counter width.
module tb_cascade_counter_reg;

  logic clk;
  logic rst_n;

  logic        c1_clear, c1_en_p, c1_en_t, c1_lv, c1_lr;
  logic [3:0]  c1_ld, c1_count;
  logic        c1_rco, c1_tc, c1_wp;
  logic [1:0]  c1_wc;

  logic        c4_clear, c4_en_p, c4_en_t, c4_lv, c4_lr;
  logic [15:0] c4_ld, c4_count;
  logic        c4_rco, c4_tc, c4_wp;
  logic [7:0]  c4_wc;

  int checks;
  int failures;

  cascade_counter_reg #(.SLICES(1), .WRAP_CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(c1_clear), .en_p(c1_en_p), .en_t(c1_en_t),
    .load_valid(c1_lv), .load_ready(c1_lr), .load_data(c1_ld), .count(c1_count),
    .rco(c1_rco), .tc_q(c1_tc), .wrap_pulse(c1_wp), .wrap_cnt(c1_wc)
  );

  cascade_counter_reg #(.SLICES(4), .WRAP_CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(c4_clear), .en_p(c4_en_p), .en_t(c4_en_t),
    .load_valid(c4_lv), .load_ready(c4_lr), .load_data(c4_ld), .count(c4_count),
    .rco(c4_rco), .tc_q(c4_tc), .wrap_pulse(c4_wp), .wrap_cnt(c4_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (c4_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", c4_count); end
    checks++; if (c4_lr !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", c4_lr); end
    checks++; if ({c4_tc, c4_wp} !== 2'b00) begin failures++; $display("FAIL reset_tc_wp got=%b exp=00", {c4_tc, c4_wp}); end
    checks++; if (c4_wc !== 8'd0) begin failures++; $display("FAIL reset_wrap_cnt got=%0d exp=0", c4_wc); end
    checks++; if (c1_count !== 4'h0) begin failures++; $display("FAIL reset_count1 got=%h exp=0", c1_count); end
    tick;
    tick;
    rst_n = 1'b1;
    checks++; if ({c1_lr, c4_lr} !== 2'b00) begin failures++; $display("FAIL ready_before_first_edge got=%b exp=00", {c1_lr, c4_lr}); end
    tick;
    checks++; if ({c1_lr, c4_lr} !== 2'b11) begin failures++; $display("FAIL ready_after_first_edge got=%b exp=11", {c1_lr, c4_lr}); end
  endtask

  task automatic test_count_slice1;
    c1_en_p = 1'b1;
    c1_en_t = 1'b1;
    for (int i = 0; i < 18; i++) begin
      checks++; if (c1_count !== 4'(i % 16)) begin failures++; $display("FAIL s1_count i=%0d got=%h exp=%h", i, c1_count, 4'(i % 16)); end
      checks++; if (c1_rco !== (i == 15)) begin failures++; $display("FAIL s1_rco i=%0d got=%b exp=%b", i, c1_rco, (i == 15)); end
      checks++; if (c1_tc !== (i == 15)) begin failures++; $display("FAIL s1_tc i=%0d got=%b exp=%b", i, c1_tc, (i == 15)); end
      checks++; if (c1_wp !== (i == 16)) begin failures++; $display("FAIL s1_wrap_pulse i=%0d got=%b exp=%b", i, c1_wp, (i == 16)); end
      checks++; if (c1_wc !== ((i >= 16) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL s1_wrap_cnt i=%0d got=%0d", i, c1_wc); end
      tick;
    end
    c1_en_p = 1'b0;
    c1_en_t = 1'b0;
  endtask

  task automatic test_back_to_back;
    c4_ld = 16'hFFFE; c4_lv = 1'b1; c4_en_p = 1'b1; c4_en_t = 1'b1;
    checks++; if (c4_lr !== 1'b1) begin failures++; $display("FAIL b2b_ready_c1 got=%b exp=1", c4_lr); end
    tick;
    checks++; if (c4_count !== 16'hFFFE) begin failures++; $display("FAIL b2b_load1 got=%h exp=fffe", c4_count); end
    checks++; if (c4_lr !== 1'b0) begin failures++; $display("FAIL b2b_ready_c2 got=%b exp=0", c4_lr); end
    tick;
    checks++; if (c4_count !== 16'hFFFF) begin failures++; $display("FAIL b2b_count_c2 got=%h exp=ffff", c4_count); end
    checks++; if ({c4_tc, c4_rco} !== 2'b11) begin failures++; $display("FAIL b2b_tc_rco got=%b exp=11", {c4_tc, c4_rco}); end
    checks++; if (c4_lr !== 1'b1) begin failures++; $display("FAIL b2b_ready_c3 got=%b exp=1", c4_lr); end
    tick;
    checks++; if (c4_count !== 16'hFFFE) begin failures++; $display("FAIL b2b_load2 got=%h exp=fffe", c4_count); end
    checks++; if ({c4_wp, c4_wc} !== 9'd0) begin failures++; $display("FAIL b2b_load_not_wrap wp=%b wc=%0d exp=0,0", c4_wp, c4_wc); end
    c4_lv = 1'b0;
    tick;
    tick;
    checks++; if (c4_count !== 16'h0000) begin failures++; $display("FAIL b2b_wrap_count got=%h exp=0000", c4_count); end
    checks++; if ({c4_wp, c4_wc} !== {1'b1, 8'd1}) begin failures++; $display("FAIL b2b_wrap wp=%b wc=%0d exp=1,1", c4_wp, c4_wc); end
    checks++; if (c4_tc !== 1'b0) begin failures++; $display("FAIL b2b_wrap_tc got=%b exp=0", c4_tc); end
    tick;
    checks++; if ({c4_count, c4_wp, c4_wc} !== {16'h0001, 1'b0, 8'd1}) begin failures++; $display("FAIL b2b_after_wrap count=%h wp=%b wc=%0d exp=0001,0,1", c4_count, c4_wp, c4_wc); end
    c4_en_p = 1'b0; c4_en_t = 1'b0;
  endtask

  task automatic test_priority;
    c4_ld = 16'h1234; c4_lv = 1'b1;
    tick;
    c4_lv = 1'b0;
    tick;
    checks++; if (c4_count !== 16'h1234) begin failures++; $display("FAIL prio_setup got=%h exp=1234", c4_count); end
    c4_clear = 1'b1; c4_lv = 1'b1; c4_ld = 16'h5555; c4_en_p = 1'b1; c4_en_t = 1'b1;
    #1;
    checks++; if (c4_lr !== 1'b0) begin failures++; $display("FAIL prio_ready_in_clear got=%b exp=0", c4_lr); end
    tick;
    checks++; if ({c4_count, c4_wc, c4_tc} !== {16'h0, 8'd0, 1'b0}) begin failures++; $display("FAIL prio_clear count=%h wc=%0d tc=%b exp=0000,0,0", c4_count, c4_wc, c4_tc); end
    c4_clear = 1'b0; c4_ld = 16'h00FF;
    #1;
    checks++; if (c4_lr !== 1'b1) begin failures++; $display("FAIL prio_ready_after_clear got=%b exp=1", c4_lr); end
    tick;
    checks++; if (c4_count !== 16'h00FF) begin failures++; $display("FAIL prio_load_over_count got=%h exp=00ff", c4_count); end
    c4_lv = 1'b0; c4_en_p = 1'b0; c4_en_t = 1'b0;
    tick;
    c4_ld = 16'hFFFF; c4_lv = 1'b1;
    tick;
    c4_lv = 1'b0;
    tick;
    checks++; if ({c4_count, c4_tc} !== {16'hFFFF, 1'b1}) begin failures++; $display("FAIL prio_load_ffff count=%h tc=%b exp=ffff,1", c4_count, c4_tc); end
    c4_ld = 16'h0000; c4_lv = 1'b1; c4_en_p = 1'b1; c4_en_t = 1'b1;
    tick;
    checks++; if ({c4_count, c4_wp, c4_wc} !== {16'h0, 1'b0, 8'd0}) begin failures++; $display("FAIL prio_load_zero_no_wrap count=%h wp=%b wc=%0d exp=0000,0,0", c4_count, c4_wp, c4_wc); end
    c4_lv = 1'b0; c4_en_p = 1'b0; c4_en_t = 1'b0;
    tick;
  endtask

  task automatic test_enables;
    c4_ld = 16'h0FFF; c4_lv = 1'b1;
    tick;
    c4_lv = 1'b0;
    tick;
    c4_en_t = 1'b0; c4_en_p = 1'b1;
    #1;
    checks++; if (c4_rco !== 1'b0) begin failures++; $display("FAIL en_t0_rco got=%b exp=0", c4_rco); end
    tick;
    checks++; if (c4_count !== 16'h0FFF) begin failures++; $display("FAIL en_t0_hold got=%h exp=0fff", c4_count); end
    c4_en_t = 1'b1; c4_en_p = 1'b0;
    #1;
    checks++; if (c4_rco !== 1'b0) begin failures++; $display("FAIL en_p0_rco_0fff got=%b exp=0", c4_rco); end
    tick;
    checks++; if (c4_count !== 16'h0FFF) begin failures++; $display("FAIL en_p0_hold got=%h exp=0fff", c4_count); end
    c4_en_t = 1'b0;
    c4_ld = 16'hFFFF; c4_lv = 1'b1;
    tick;
    c4_lv = 1'b0;
    tick;
    checks++; if (c4_rco !== 1'b0) begin failures++; $display("FAIL en_t0_rco_ffff got=%b exp=0", c4_rco); end
    c4_en_t = 1'b1;
    #1;
    checks++; if (c4_rco !== 1'b1) begin failures++; $display("FAIL en_p0_rco_ffff got=%b exp=1", c4_rco); end
    tick;
    tick;
    checks++; if ({c4_count, c4_wp, c4_wc} !== {16'hFFFF, 1'b0, 8'd0}) begin failures++; $display("FAIL en_p0_no_wrap count=%h wp=%b wc=%0d exp=ffff,0,0", c4_count, c4_wp, c4_wc); end
    c4_en_t = 1'b0;
  endtask

  task automatic test_saturation;
    int exp_cnt;
    int wraps;
    int pulses;
    logic exp_wp;
    c1_clear = 1'b1;
    tick;
    c1_clear = 1'b0;
    checks++; if ({c1_count, c1_wc} !== 6'd0) begin failures++; $display("FAIL sat_clear count=%h wc=%0d exp=0,0", c1_count, c1_wc); end
    c1_en_p = 1'b1; c1_en_t = 1'b1;
    exp_cnt = 0; wraps = 0; pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick;
      exp_cnt = (exp_cnt + 1) % 16;
      exp_wp  = (exp_cnt == 0);
      if (exp_wp) wraps++;
      if (c1_wp) pulses++;
      checks++; if (c1_count !== 4'(exp_cnt)) begin failures++; $display("FAIL sat_count i=%0d got=%h exp=%h", i, c1_count, 4'(exp_cnt)); end
      checks++; if (c1_wp !== exp_wp) begin failures++; $display("FAIL sat_pulse i=%0d got=%b exp=%b", i, c1_wp, exp_wp); end
      checks++; if (c1_wc !== 2'((wraps > 3) ? 3 : wraps)) begin failures++; $display("FAIL sat_wrap_cnt i=%0d got=%0d exp=%0d", i, c1_wc, (wraps > 3) ? 3 : wraps); end
    end
    checks++; if (pulses != 5) begin failures++; $display("FAIL sat_pulse_total got=%0d exp=5", pulses); end
    c1_en_p = 1'b0; c1_en_t = 1'b0;
  endtask

  task automatic test_async_reset;
    c4_ld = 16'h0009; c4_lv = 1'b1;
    tick;
    c4_lv = 1'b0; c4_en_p = 1'b1; c4_en_t = 1'b1;
    tick;
    checks++; if (c4_count !== 16'h000A) begin failures++; $display("FAIL arst_setup got=%h exp=000a", c4_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({c4_count, c4_lr, c4_wc} !== {16'h0, 1'b0, 8'd0}) begin failures++; $display("FAIL arst_immediate count=%h ready=%b wc=%0d exp=0000,0,0", c4_count, c4_lr, c4_wc); end
    c4_en_p = 1'b0; c4_en_t = 1'b0;
    c4_ld = 16'h1111; c4_lv = 1'b1;
    tick;
    rst_n = 1'b1;
    checks++; if (c4_lr !== 1'b0) begin failures++; $display("FAIL arst_ready_released got=%b exp=0", c4_lr); end
    tick;
    checks++; if ({c4_count, c4_lr} !== {16'h0, 1'b1}) begin failures++; $display("FAIL arst_first_edge count=%h ready=%b exp=0000,1", c4_count, c4_lr); end
    tick;
    checks++; if (c4_count !== 16'h1111) begin failures++; $display("FAIL arst_load_after got=%h exp=1111", c4_count); end
    c4_lv = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    c1_clear = 1'b0; c1_en_p = 1'b0; c1_en_t = 1'b0; c1_lv = 1'b0; c1_ld = 4'h0;
    c4_clear = 1'b0; c4_en_p = 1'b0; c4_en_t = 1'b0; c4_lv = 1'b0; c4_ld = 16'h0;
    test_reset;
    test_count_slice1;
    test_back_to_back;
    test_priority;
    test_enables;
    test_saturation;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
